// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer
//   Circular FIFO that decouples the fetch stage from the decode stage.
//   Each entry holds {instruction, PC, PC+4}. When the buffer is empty the
//   decode side sees a bubble (NOP_INSTR, PC=0, PC+4=0).
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (highest priority)
//   flush     : redirect from execute; empties the buffer at the edge
//   in_valid  : fetch offers InstrF/PCF/PCPlus4F
//   InstrF    : fetched instruction
//   PCF       : PC of InstrF
//   PCPlus4F  : PCF + 4
//   in_ready  : buffer has room; fetch advances its PC on in_valid && in_ready
//   out_valid : head entry is valid toward decode
//   out_ready : decode accepts the head entry
//   InstrD    : head instruction or NOP_INSTR when empty
//   PCD       : head PC or 0 when empty
//   PCPlus4D  : head PC+4 or 0 when empty
//   count     : current occupancy
//
// Handshake: a transfer happens on a side exactly at a rising edge where both
// valid and ready are high. in_ready depends only on the registered count and
// out_valid/data only on registered state, so neither side has a
// combinational path from the other side's inputs. A flush in the same cycle
// cancels both transfers.

module fetch_decode_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    InstrF,
  input  logic [ADDRESS_WIDTH-1:0] PCF,
  input  logic [ADDRESS_WIDTH-1:0] PCPlus4F,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic [CW-1:0]            count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc4_mem   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic push;
  logic pop;

  assign in_ready  = (cnt < FULL_CNT);
  assign out_valid = (cnt != '0);
  assign count     = cnt;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Storage is not reset; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem[wr_ptr] <= InstrF;
      pc_mem[wr_ptr]    <= PCF;
      pc4_mem[wr_ptr]   <= PCPlus4F;
    end
  end

  always_comb begin
    InstrD   = NOP_INSTR;
    PCD      = '0;
    PCPlus4D = '0;
    if (out_valid) begin
      InstrD   = instr_mem[rd_ptr];
      PCD      = pc_mem[rd_ptr];
      PCPlus4D = pc4_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed testbench for fetch_decode_buffer (DEPTH=2) with a queue-based
// reference model of the buffer contents.

module tb_fetch_decode_buffer;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [31:0]   InstrF, PCF, PCPlus4F;
  logic          in_ready, out_valid;
  logic [31:0]   InstrD, PCD, PCPlus4D;
  logic [CW-1:0] count;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fetch_decode_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .count(count)
  );

  // ---------------- scoreboard ----------------
  logic [95:0] exp_q[$];    // {instr, pc, pc4}, head = next expected output
  logic [31:0] popped[$];   // PCs observed leaving the buffer
  int vectors    = 0;
  int miscompares = 0;
  bit model_ok   = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [95:0] head;
    int sz;
    sz   = exp_q.size();
    head = (sz != 0) ? exp_q[0] : {NOP, 32'd0, 32'd0};
    chk("out_valid", 96'(out_valid), 96'(sz != 0));
    chk("in_ready",  96'(in_ready),  96'(sz < DEPTH));
    chk("count",     96'(count),     96'(sz));
    chk("InstrD",    96'(InstrD),    96'(head[95:64]));
    chk("PCD",       96'(PCD),       96'(head[63:32]));
    chk("PCPlus4D",  96'(PCPlus4D),  96'(head[31:0]));
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check current outputs, clock, update model.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, output logic acc);
    logic do_push, do_pop;
    rst = r; flush = f; in_valid = iv; InstrF = ins; PCF = pc;
    PCPlus4F = pc + 32'd4; out_ready = ordy;
    #1;
    if (model_ok) check_outputs();
    do_push = iv && (exp_q.size() < DEPTH) && !f;
    do_pop  = (exp_q.size() != 0) && ordy && !f;
    acc = do_push && !r;
    if (do_pop && !r) popped.push_back(PCD);
    @(posedge clk); #1;
    if (r || f) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({ins, pc, pc + 32'd4});
    end
    if (r) model_ok = 1;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cyc(0, 0, 0, 32'h0, 32'h0, ordy, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) idle(1);
  endtask

  task automatic chk_popped(input string tag, input logic [31:0] p0,
                            input logic [31:0] p1, input logic [31:0] p2, input int n);
    logic [31:0] e[3];
    e[0] = p0; e[1] = p1; e[2] = p2;
    chk({tag, "_n"}, 96'(popped.size()), 96'(n));
    for (int i = 0; i < n; i++)
      chk(tag, 96'((i < popped.size()) ? popped[i] : 32'hDEAD_BEEF), 96'(e[i]));
    popped.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic a;
    int tries;

    // Reset then idle
    cyc(1, 0, 0, 32'h0, 32'h0, 0, a);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, a);
    idle(0);
    chk("rst_instr", 96'(InstrD), 96'(32'h00000013));
    chk("rst_pc",    96'(PCD), 96'(0));
    chk("rst_count", 96'(count), 96'(0));
    chk("rst_inrdy", 96'(in_ready), 96'(1));
    chk("rst_ovld",  96'(out_valid), 96'(0));

    // Streaming
    popped.delete();
    cyc(0, 0, 1, 32'h00500093, 32'h0, 1, a);
    cyc(0, 0, 1, 32'h00A00113, 32'h4, 1, a);
    chk("stream_cnt", 96'(count), 96'(1));
    cyc(0, 0, 1, 32'h002081B3, 32'h8, 1, a);
    chk("stream_pc4", 96'(PCPlus4D), 96'(32'hC));
    drain();
    chk_popped("stream", 32'h0, 32'h4, 32'h8, 3);

    // Backpressure
    cyc(0, 0, 1, 32'h11, 32'h10, 0, a);
    cyc(0, 0, 1, 32'h12, 32'h14, 0, a);
    chk("bp_full_cnt", 96'(count), 96'(2));
    chk("bp_full_rdy", 96'(in_ready), 96'(0));
    cyc(0, 0, 1, 32'h13, 32'h18, 0, a);
    chk("bp_rejected", 96'(a), 96'(0));
    tries = 0;
    a = 0;
    while (!a && tries < 10) begin
      cyc(0, 0, 1, 32'h13, 32'h18, 1, a);
      tries++;
    end
    chk("bp_accept_timeout", 96'(a), 96'(1));
    chk("bp_accept_cycles", 96'(tries), 96'(2));
    drain();
    chk_popped("bp_order", 32'h10, 32'h14, 32'h18, 3);

    // Flush while full
    cyc(0, 0, 1, 32'h21, 32'h20, 0, a);
    cyc(0, 0, 1, 32'h22, 32'h24, 0, a);
    cyc(0, 1, 1, 32'h23, 32'h28, 1, a);
    chk("fl_count", 96'(count), 96'(0));
    chk("fl_ovld",  96'(out_valid), 96'(0));
    chk("fl_instr", 96'(InstrD), 96'(32'h00000013));
    chk("fl_inrdy", 96'(in_ready), 96'(1));
    cyc(0, 0, 1, 32'h99, 32'h100, 1, a);
    chk("fl_new_pc", 96'(PCD), 96'(32'h100));
    drain();
    chk_popped("fl_order", 32'h100, 32'h0, 32'h0, 1);

    // Wrap with simultaneous push/pop
    cyc(0, 0, 1, 32'h200, 32'h200, 1, a);
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 0, 1, 32'h200 + 32'(i), 32'h200 + 32'(4 * i), 1, a);
      chk("wrap_cnt", 96'(count), 96'(1));
      chk("wrap_pc", 96'(PCD), 96'(32'h200 + 32'(4 * i)));
    end
    drain();
    chk("wrap_n", 96'(popped.size()), 96'(8));
    popped.delete();

    // Reset with flush while full
    cyc(0, 0, 1, 32'h31, 32'h30, 0, a);
    cyc(0, 0, 1, 32'h32, 32'h34, 0, a);
    chk("mr_full", 96'(count), 96'(2));
    cyc(1, 1, 1, 32'h33, 32'h38, 0, a);
    chk("mr_count", 96'(count), 96'(0));
    chk("mr_ovld",  96'(out_valid), 96'(0));
    chk("mr_instr", 96'(InstrD), 96'(32'h00000013));
    chk("mr_pc4",   96'(PCPlus4D), 96'(0));
    cyc(0, 0, 1, 32'h0040_0093, 32'h300, 1, a);
    chk("mr_new_instr", 96'(InstrD), 96'(32'h0040_0093));
    chk("mr_new_pc4", 96'(PCPlus4D), 96'(32'h304));
    drain();
    chk_popped("mr_order", 32'h300, 32'h0, 32'h0, 1);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      cyc(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
          $urandom, 32'(4 * i), $urandom_range(0, 1), a);
    end
    drain();

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Decoupling buffer between the fetch stage (PC + instruction memory) and the decode stage.
- Captures each fetched instruction together with its PC and PC+4 in a small circular FIFO, using a valid/ready handshake on both sides.
- in_ready is used by fetch as its PC-advance enable, so fetch stalls when the buffer is full.
- flush discards every queued instruction on a taken branch, jal or jalr redirect.

Parameters:
- DATA_WIDTH, 32, instruction width
- ADDRESS_WIDTH, 32, PC width
- DEPTH, 2, number of FIFO entries; any integer >= 1, power of two not required
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) driven on InstrD when empty

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  redirect from execute (PCSrc or jalrmuxSel taken); empties buffer
- in_valid  input  1  fetch presents a valid instruction this cycle
- InstrF  input  DATA_WIDTH  fetched instruction
- PCF  input  ADDRESS_WIDTH  PC of InstrF
- PCPlus4F  input  ADDRESS_WIDTH  PCF + 4
- in_ready  output  1  buffer can accept; fetch advances PC only when in_valid && in_ready
- out_valid  output  1  head entry valid toward decode
- out_ready  input  1  decode accepts the head entry (decode not stalled)
- InstrD  output  DATA_WIDTH  head instruction, or NOP_INSTR when empty
- PCD  output  ADDRESS_WIDTH  head PC, or 0 when empty
- PCPlus4D  output  ADDRESS_WIDTH  head PC+4, or 0 when empty
- count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- State: storage array[DEPTH] of {Instr, PC, PCPlus4}, wr_ptr, rd_ptr, count.
- Reset (synchronous, rst=1 at the edge): wr_ptr = rd_ptr = count = 0. Storage contents are don't-care.
  - Resulting outputs: out_valid=0, in_ready=1, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, count=0.
  - rst has priority over flush, push and pop.
- in_ready = (count < DEPTH). Purely a function of registered count; no combinational path from out_ready.
- out_valid = (count != 0). InstrD, PCD and PCPlus4D come from the entry at rd_ptr when out_valid=1, otherwise NOP_INSTR/0/0.
- push = in_valid && in_ready && !flush. On push, write entry at wr_ptr and advance wr_ptr.
- pop = out_valid && out_ready && !flush. On pop, advance rd_ptr.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0. Explicit compare, so non-power-of-two DEPTH works.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; both pointers advance
- Full (count == DEPTH): in_ready=0, so no push even if a pop occurs that cycle. in_ready reasserts the cycle after the pop.
- Empty: out_valid=0 and bubble outputs; out_ready is ignored.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (1 cycle). There is no fall-through bypass.
- Throughput: with DEPTH >= 2, one instruction per cycle is sustained when out_ready=1 continuously. With DEPTH=1, throughput is one instruction per 2 cycles.
- flush (synchronous): at the edge, wr_ptr = rd_ptr = count = 0.
  - The instruction offered that cycle is dropped and no pop is counted.
  - Next cycle: out_valid=0, in_ready=1.
  - Fetch presents the redirected PC's instruction from the following cycle on.
- flush and rst on the same edge: reset result. A flush in the middle of a stall behaves identically.
- No overflow or underflow is possible. The handshake gates all writes and reads.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, then rst=0 with in_valid=0 -> out_valid=0, InstrD=32'h00000013, PCD=0, count=0, in_ready=1.
- Streaming, DEPTH=2: out_ready=1; push InstrF=0x00500093/PCF=0x0, then 0x00A00113/0x4, then 0x002081B3/0x8 on consecutive cycles -> same triples appear on InstrD/PCD one cycle later, in order, PCPlus4D=0x4/0x8/0xC, count stays 1, in_ready stays 1.
- Backpressure: out_ready=0 while pushing PCF=0x10, 0x14, 0x18 -> count reaches 2, in_ready=0 after the second push, 0x18 is not accepted. Raise out_ready -> PCD=0x10, then 0x14. in_ready=1 one cycle after the first pop; 0x18 is then accepted and emerges third.
- Flush while full: buffer holds PCF=0x20, 0x24; assert flush with in_valid=1, PCF=0x28 -> next cycle count=0, out_valid=0, InstrD=NOP. Push PCF=0x100 -> PCD=0x100 appears next, with no stale 0x20/0x24/0x28.
- Wrap and simultaneous push/pop: run 7 consecutive push+pop cycles at count=1 with incrementing PCs -> pointers wrap past DEPTH-1, order preserved, count constant at 1.
- Reset mid-operation: count=2 with rst and flush asserted together -> reset outputs next cycle, and the first post-reset push appears correctly.
